// File: rtl/usbh_arb_pkg.sv
// usbh_arb_pkg: shared state encoding, defaults and width helper for the register-bus arbiter
package usbh_arb_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam int TO_CYC_DEF = 255;
  function automatic int cw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/usbh_rr_pick.sv
// usbh_rr_pick: combinational round-robin picker, first asserted request at or after ptr
module usbh_rr_pick
  import usbh_arb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int PW   = cw(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);
  logic [PW-1:0] j;
  always_comb begin
    idx = '0;
    j   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = PW'((int'(ptr) + k) % NREQ);
      if (req[j]) idx = j;
    end
    any = |req;
    gnt = any ? NREQ'(1) << idx : '0;
  end
endmodule

// File: rtl/usbh_reg_arb.sv
// usbh_reg_arb: round-robin arbiter sharing the USB host core register bus, with a transfer watchdog
module usbh_reg_arb
  import usbh_arb_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int AW     = 6,
  parameter int DW     = 32,
  parameter int TO_CYC = TO_CYC_DEF
) (
  input  logic                 usb_clk_i,
  input  logic                 usb_rst_i,
  input  logic [NREQ-1:0]      req_cs_i,
  input  logic [NREQ-1:0]      req_wr_i,
  input  logic [NREQ*AW-1:0]   req_addr_i,
  input  logic [NREQ*DW-1:0]   req_wdata_i,
  input  logic [NREQ*DW/8-1:0] req_be_i,
  output logic [DW-1:0]        req_rdata_o,
  output logic [NREQ-1:0]      req_ack_o,
  output logic [NREQ-1:0]      req_err_o,
  output logic [NREQ-1:0]      gnt_o,
  output logic                 reg_cs_o,
  output logic                 reg_wr_o,
  output logic [AW-1:0]        reg_addr_o,
  output logic [DW-1:0]        reg_wdata_o,
  output logic [DW/8-1:0]      reg_be_o,
  input  logic [DW-1:0]        reg_rdata_i,
  input  logic                 reg_ack_i
);
  localparam int PW = cw(NREQ);
  localparam int WW = cw(TO_CYC + 1);
  localparam int BW = DW / 8;
  state_t state, state_n;
  logic [PW-1:0] ptr, pk_idx;
  logic [NREQ-1:0] pk_gnt;
  logic pk_any, to;
  logic [WW-1:0] wd;
  usbh_rr_pick #(.NREQ(NREQ), .PW(PW)) u_pick (
    .req(req_cs_i),
    .ptr(ptr),
    .gnt(pk_gnt),
    .idx(pk_idx),
    .any(pk_any)
  );
  always_comb begin
    to      = (TO_CYC != 0) && (wd == WW'(TO_CYC - 1));
    state_n = (state == IDLE) ? (pk_any ? BUSY : IDLE) :
              (state == BUSY) ? ((reg_ack_i || to) ? DONE : BUSY) : IDLE;
  end
  always_ff @(posedge usb_clk_i) begin
    if (usb_rst_i) begin
      state       <= IDLE;
      ptr         <= '0;
      wd          <= '0;
      gnt_o       <= '0;
      reg_cs_o    <= 1'b0;
      reg_wr_o    <= 1'b0;
      reg_addr_o  <= '0;
      reg_wdata_o <= '0;
      reg_be_o    <= '0;
      req_rdata_o <= '0;
      req_ack_o   <= '0;
      req_err_o   <= '0;
    end else begin
      state <= state_n;
      case (state)
        IDLE: if (pk_any) begin
          gnt_o       <= pk_gnt;
          ptr         <= (pk_idx == PW'(NREQ - 1)) ? '0 : pk_idx + 1'b1;
          wd          <= '0;
          reg_cs_o    <= 1'b1;
          reg_wr_o    <= req_wr_i[pk_idx];
          reg_addr_o  <= req_addr_i[pk_idx*AW +: AW];
          reg_wdata_o <= req_wdata_i[pk_idx*DW +: DW];
          reg_be_o    <= req_be_i[pk_idx*BW +: BW];
        end
        BUSY: begin
          wd <= wd + 1'b1;
          if (reg_ack_i) begin
            reg_cs_o    <= 1'b0;
            req_ack_o   <= gnt_o;
            req_rdata_o <= reg_wr_o ? '0 : reg_rdata_i;
          end else if (to) begin
            reg_cs_o    <= 1'b0;
            req_err_o   <= gnt_o;
            req_rdata_o <= '0;
          end
        end
        default: begin
          gnt_o       <= '0;
          req_ack_o   <= '0;
          req_err_o   <= '0;
          req_rdata_o <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_usbh_reg_arb.sv
// tb_usbh_reg_arb: scoreboard bench with a behavioural core responder for usbh_reg_arb
module tb_usbh_reg_arb;
  localparam int N = 2, AW = 6, DW = 32, TO = 8;
  typedef struct {
    int idx;
    logic wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [3:0] be;
  } bus_t;
  typedef struct {
    int idx;
    logic ok;
    logic [DW-1:0] rdata;
    int len;
  } rsp_t;
  logic usb_clk_i = 1'b0, usb_rst_i = 1'b1;
  logic [N-1:0] req_cs_i = '0, req_wr_i = '0;
  logic [N*AW-1:0] req_addr_i = '0;
  logic [N*DW-1:0] req_wdata_i = '0;
  logic [N*4-1:0] req_be_i = '0;
  logic [DW-1:0] req_rdata_o, reg_wdata_o, reg_rdata_i = '0;
  logic [N-1:0] req_ack_o, req_err_o, gnt_o;
  logic reg_cs_o, reg_wr_o, reg_ack_i = 1'b0;
  logic [AW-1:0] reg_addr_o;
  logic [3:0] reg_be_o;
  bus_t bq[$];
  rsp_t rq[$];
  bus_t cur;
  int n_chk = 0, n_pass = 0, rcyc = 0, cs_len = 0;
  int lat_r[N], pend[N];
  logic [DW-1:0] rdat_r[N];
  bit prev_cs = 0;
  usbh_reg_arb #(.NREQ(N), .AW(AW), .DW(DW), .TO_CYC(TO)) dut (
    .usb_clk_i(usb_clk_i), .usb_rst_i(usb_rst_i),
    .req_cs_i(req_cs_i), .req_wr_i(req_wr_i), .req_addr_i(req_addr_i),
    .req_wdata_i(req_wdata_i), .req_be_i(req_be_i),
    .req_rdata_o(req_rdata_o), .req_ack_o(req_ack_o), .req_err_o(req_err_o),
    .gnt_o(gnt_o), .reg_cs_o(reg_cs_o), .reg_wr_o(reg_wr_o), .reg_addr_o(reg_addr_o),
    .reg_wdata_o(reg_wdata_o), .reg_be_o(reg_be_o),
    .reg_rdata_i(reg_rdata_i), .reg_ack_i(reg_ack_i)
  );
  always #5 usb_clk_i = ~usb_clk_i;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask
  task automatic step();
    rsp_t r;
    @(negedge usb_clk_i);
    if (reg_cs_o && !prev_cs) begin
      if (bq.size() == 0) chk("bus_unexpected", 64'(1), 64'(0));
      else begin
        cur = bq.pop_front();
        chk("gnt", 64'(gnt_o), 64'(1) << cur.idx);
      end
      cs_len = 0;
      rcyc = 0;
    end
    if (reg_cs_o) begin
      chk("bus", 64'({reg_wr_o, reg_addr_o, reg_wdata_o, reg_be_o}),
          64'({cur.wr, cur.addr, cur.wdata, cur.be}));
      cs_len++;
    end
    if ((req_ack_o | req_err_o) != '0) begin
      if (rq.size() == 0) chk("rsp_unexpected", 64'({req_ack_o, req_err_o}), 64'(0));
      else begin
        r = rq.pop_front();
        chk("ack", 64'(req_ack_o), r.ok ? 64'(1) << r.idx : 64'(0));
        chk("err", 64'(req_err_o), r.ok ? 64'(0) : 64'(1) << r.idx);
        chk("rdata", 64'(req_rdata_o), 64'(r.rdata));
        chk("cs_len", 64'(cs_len), 64'(r.len));
      end
      for (int i = 0; i < N; i++)
        if (req_ack_o[i] || req_err_o[i]) begin
          pend[i]--;
          if (pend[i] <= 0) req_cs_i[i] = 1'b0;
        end
    end
    prev_cs = reg_cs_o;
    reg_ack_i = 1'b0;
    if (reg_cs_o) begin
      if (rcyc == lat_r[cur.idx]) begin
        reg_ack_i = 1'b1;
        reg_rdata_i = rdat_r[cur.idx];
      end
      rcyc++;
    end
  endtask
  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask
  task automatic wait_done();
    int b = 0;
    while ((pend[0] > 0 || pend[1] > 0 || rq.size() > 0) && b < 200) begin
      step();
      b++;
    end
    chk("done_in_time", 64'(b < 200), 64'(1));
    run(2);
  endtask
  task automatic issue(input int i, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [3:0] be, input int lat, input logic [DW-1:0] rd, input int cnt);
    req_cs_i[i] = 1'b1;
    req_wr_i[i] = wr;
    req_addr_i[i*AW +: AW] = a;
    req_wdata_i[i*DW +: DW] = d;
    req_be_i[i*4 +: 4] = be;
    lat_r[i] = lat;
    rdat_r[i] = rd;
    pend[i] += cnt;
  endtask
  task automatic expect_bus(input int i);
    bus_t b;
    b.idx = i;
    b.wr = req_wr_i[i];
    b.addr = req_addr_i[i*AW +: AW];
    b.wdata = req_wdata_i[i*DW +: DW];
    b.be = req_be_i[i*4 +: 4];
    bq.push_back(b);
  endtask
  task automatic expect_x(input int i, input logic ok, input logic [DW-1:0] rd, input int len);
    rsp_t r;
    expect_bus(i);
    r.idx = i;
    r.ok = ok;
    r.rdata = rd;
    r.len = len;
    rq.push_back(r);
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, 64'({gnt_o, reg_cs_o, reg_wr_o, req_ack_o, req_err_o, reg_addr_o, reg_be_o}), 64'(0));
    chk(tag, {reg_wdata_o, req_rdata_o}, 64'(0));
  endtask
  task automatic do_reset();
    usb_rst_i = 1'b1;
    req_cs_i = '0;
    pend[0] = 0;
    pend[1] = 0;
    run(2);
    usb_rst_i = 1'b0;
  endtask
  initial begin
    pend[0] = 0;
    pend[1] = 0;
    run(3);
    chk_zero("reset");
    usb_rst_i = 1'b0;
    run(2);
    issue(0, 1'b0, 6'h04, 32'h0, 4'hF, 3, 32'hA5A5_0001, 1);
    expect_x(0, 1'b1, 32'hA5A5_0001, 4);
    step();
    chk("cs_latency", 64'(reg_cs_o), 64'(1));
    wait_done();
    do_reset();
    run(1);
    issue(0, 1'b0, 6'h10, 32'h0, 4'hF, 0, 32'h0000_0100, 2);
    issue(1, 1'b0, 6'h20, 32'h0, 4'hF, 0, 32'h0000_0200, 2);
    expect_x(0, 1'b1, 32'h100, 1);
    expect_x(1, 1'b1, 32'h200, 1);
    expect_x(0, 1'b1, 32'h100, 1);
    expect_x(1, 1'b1, 32'h200, 1);
    wait_done();
    issue(0, 1'b0, 6'h08, 32'h0, 4'hF, 1000, 32'hFFFF_0008, 1);
    issue(1, 1'b0, 6'h09, 32'h0, 4'hF, 0, 32'h0000_0099, 1);
    expect_x(0, 1'b0, 32'h0, TO);
    expect_x(1, 1'b1, 32'h99, 1);
    wait_done();
    issue(1, 1'b0, 6'h11, 32'h0, 4'hF, TO - 1, 32'h0000_0077, 1);
    expect_x(1, 1'b1, 32'h77, TO);
    wait_done();
    issue(0, 1'b1, 6'h05, 32'hCAFE_F00D, 4'hF, 1000, 32'h0, 1);
    expect_bus(0);
    run(2);
    usb_rst_i = 1'b1;
    req_cs_i = '0;
    pend[0] = 0;
    step();
    chk_zero("reset_mid_busy");
    usb_rst_i = 1'b0;
    run(2);
    issue(0, 1'b0, 6'h01, 32'h0, 4'hF, 0, 32'h0000_0A00, 1);
    issue(1, 1'b0, 6'h02, 32'h0, 4'hF, 0, 32'h0000_0B00, 1);
    expect_x(0, 1'b1, 32'hA00, 1);
    expect_x(1, 1'b1, 32'hB00, 1);
    wait_done();
    issue(1, 1'b1, 6'h2A, 32'h1234_5678, 4'b0011, 4, 32'hDEAD_BEEF, 1);
    expect_x(1, 1'b1, 32'h0, 5);
    run(2);
    req_wr_i[1] = 1'b0;
    req_addr_i[AW +: AW] = 6'h3F;
    req_wdata_i[DW +: DW] = 32'h0BAD_0BAD;
    req_be_i[4 +: 4] = 4'b1100;
    wait_done();
    chk("queues_empty", 64'(bq.size() + rq.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
